// File: rtl/react_test_ctrl_if.sv
// Player/display side of the reaction-time game controller.
// The master drives enable and keypress, and the slave returns status and timing.
interface react_test_ctrl_if;
   logic        iEnable;
   logic        iPress;
   logic [2:0]  oState;
   logic        oGo;
   logic [13:0] oTimeMs;
   logic        oValid;
   logic [13:0] oBest;

   modport master (
      output iEnable, iPress,
      input  oState, oGo, oTimeMs, oValid, oBest
   );

   modport slave (
      input  iEnable, iPress,
      output oState, oGo, oTimeMs, oValid, oBest
   );
endinterface

// File: rtl/react_test_ctrl.sv
// Reaction-time game controller. It waits a random delay, raises GO, and then measures
// the keypress latency in ms. It also keeps the best valid time seen since reset.
module react_test_ctrl #(
   parameter int TICKS_PER_MS = 50000,
   parameter int MIN_DELAY_MS = 1000,
   parameter int MAX_MS       = 9999
) (
   input  logic             clk,
   input  logic             iReset,
   react_test_ctrl_if.slave bus
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_ARMED   = 3'd1;
   localparam logic [2:0] ST_GO      = 3'd2;
   localparam logic [2:0] ST_RESULT  = 3'd3;
   localparam logic [2:0] ST_EARLY   = 3'd4;
   localparam logic [2:0] ST_TIMEOUT = 3'd5;

   localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
   localparam int DW = $clog2(MIN_DELAY_MS + 2048);

   localparam logic [10:0] LFSR_SEED = 11'h5A5;
   localparam logic [13:0] BEST_INIT = 14'h3FFF;

   // Fibonacci step for x^11 + x^9 + 1. A nonzero state never reaches zero.
   function automatic logic [10:0] lfsr_next(input logic [10:0] cur);
      lfsr_next = {cur[9:0], cur[10] ^ cur[8]};
   endfunction

   logic [2:0]    state_r, state_nxt_s;
   logic [10:0]   lfsr_r;
   logic [PW-1:0] presc_r, presc_nxt_s;
   logic          tick_s;
   logic [DW-1:0] delay_r, delay_nxt_s, delay_seed_s;
   logic [13:0]   count_r, count_nxt_s, count_inc_s;
   logic [13:0]   time_r, time_nxt_s;
   logic [13:0]   best_r, best_nxt_s;
   logic          valid_r, valid_nxt_s;
   logic          go_r;

   // Derive the ms tick, the next count value and a fresh random delay.
   always_comb begin
      tick_s       = (presc_r == PW'(TICKS_PER_MS - 1));
      count_inc_s  = tick_s ? (count_r + 14'd1) : count_r;
      delay_seed_s = DW'(MIN_DELAY_MS) + DW'(lfsr_r);
   end

   // Next-state, counter and result decode.
   always_comb begin
      state_nxt_s = state_r;
      delay_nxt_s = delay_r;
      count_nxt_s = count_r;
      time_nxt_s  = time_r;
      best_nxt_s  = best_r;
      valid_nxt_s = 1'b0;
      if (!bus.iEnable) begin
         state_nxt_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.iPress) begin
                  state_nxt_s = ST_ARMED;
                  delay_nxt_s = delay_seed_s;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            // A press beats the expiry of the delay that lands on the same cycle.
            ST_ARMED: begin
               if (bus.iPress) begin
                  state_nxt_s = ST_EARLY;
               end else if (tick_s) begin
                  if (delay_r <= DW'(1)) begin
                     state_nxt_s = ST_GO;
                     count_nxt_s = 14'd0;
                  end else begin
                     delay_nxt_s = delay_r - DW'(1);
                  end
               end else begin
                  state_nxt_s = ST_ARMED;
               end
            end
            ST_GO: begin
               if (bus.iPress) begin
                  state_nxt_s = ST_RESULT;
                  time_nxt_s  = count_inc_s;
                  valid_nxt_s = 1'b1;
                  if (count_inc_s < best_r) begin
                     best_nxt_s = count_inc_s;
                  end else begin
                     best_nxt_s = best_r;
                  end
               end else if (count_inc_s >= 14'(MAX_MS)) begin
                  state_nxt_s = ST_TIMEOUT;
                  time_nxt_s  = 14'(MAX_MS);
               end else begin
                  count_nxt_s = count_inc_s;
               end
            end
            ST_RESULT, ST_EARLY, ST_TIMEOUT: begin
               if (bus.iPress) begin
                  state_nxt_s = ST_ARMED;
                  delay_nxt_s = delay_seed_s;
               end else begin
                  state_nxt_s = state_r;
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
            end
         endcase
      end
   end

   // Restart the ms prescaler on every state change, so the first ms after entry is full length.
   always_comb begin
      if (state_nxt_s != state_r) begin
         presc_nxt_s = '0;
      end else if (tick_s) begin
         presc_nxt_s = '0;
      end else begin
         presc_nxt_s = presc_r + PW'(1);
      end
   end

   // State, timing and output registers.
   always_ff @(posedge clk or posedge iReset) begin
      if (iReset) begin
         state_r <= ST_IDLE;
         lfsr_r  <= LFSR_SEED;
         presc_r <= '0;
         delay_r <= '0;
         count_r <= 14'd0;
         time_r  <= 14'd0;
         best_r  <= BEST_INIT;
         valid_r <= 1'b0;
         go_r    <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         lfsr_r  <= lfsr_next(lfsr_r);
         presc_r <= presc_nxt_s;
         delay_r <= delay_nxt_s;
         count_r <= count_nxt_s;
         time_r  <= time_nxt_s;
         best_r  <= best_nxt_s;
         valid_r <= valid_nxt_s;
         go_r    <= (state_nxt_s == ST_GO);
      end
   end

   assign bus.oState  = state_r;
   assign bus.oGo     = go_r;
   assign bus.oTimeMs = time_r;
   assign bus.oValid  = valid_r;
   assign bus.oBest   = best_r;

endmodule

// File: tb/tb_react_test_ctrl.sv
// Directed bench for react_test_ctrl with 4 clocks per ms, a 3 ms minimum delay and a 20 ms timeout.
module tb_react_test_ctrl;

   logic clk;
   logic iReset;
   int   checks;
   int   failures;
   logic [10:0] lfsr_m;
   logic [10:0] lval;
   int   n;
   bit   go_seen;

   react_test_ctrl_if bus();

   react_test_ctrl #(
      .TICKS_PER_MS(4),
      .MIN_DELAY_MS(3),
      .MAX_MS      (20)
   ) dut (
      .clk   (clk),
      .iReset(iReset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference LFSR for x^11 + x^9 + 1, seeded with 11'h5A5.
   always @(posedge clk or posedge iReset) begin
      if (iReset) lfsr_m <= 11'h5A5;
      else        lfsr_m <= {lfsr_m[9:0], lfsr_m[10] ^ lfsr_m[8]};
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic wait_cycles(input int k);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Pulse iPress for one cycle and return the LFSR value that the DUT samples at that edge.
   task automatic press_key(output logic [10:0] l);
      l = lfsr_m;
      bus.iPress = 1'b1;
      @(posedge clk);
      #1;
      bus.iPress = 1'b0;
   endtask

   // Wait for GO after an arming press, count the cycles, and check the delay.
   task automatic wait_go(input string tag, input logic [10:0] l);
      int bound;
      bound = 4 * (3 + 2047) + 8;
      n = 0;
      go_seen = 1'b0;
      while (n < bound) begin
         @(posedge clk);
         #1;
         n++;
         if (bus.oState == 3'd2) break;
         if (bus.oGo) go_seen = 1'b1;
      end
      check_val({tag, "_delay"}, n, 4 * (3 + l));
      check_val({tag, "_go_early"}, {31'd0, go_seen}, 32'd0);
      check_val({tag, "_ogo"}, {31'd0, bus.oGo}, 32'd1);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      iReset = 1'b1;
      bus.iEnable = 1'b0;
      bus.iPress = 1'b0;
      wait_cycles(3);
      check_val("rst_state", {29'd0, bus.oState}, 32'd0);
      check_val("rst_go", {31'd0, bus.oGo}, 32'd0);
      check_val("rst_valid", {31'd0, bus.oValid}, 32'd0);
      check_val("rst_time", {18'd0, bus.oTimeMs}, 32'd0);
      check_val("rst_best", {18'd0, bus.oBest}, 32'h3FFF);
      iReset = 1'b0;
      wait_cycles(2);
      bus.iEnable = 1'b1;
      wait_cycles(1);

      // Run 1: arm the game, then press after 7 ms.
      press_key(lval);
      check_val("arm1_state", {29'd0, bus.oState}, 32'd1);
      wait_go("run1", lval);
      wait_cycles(28);
      press_key(lval);
      check_val("run1_state", {29'd0, bus.oState}, 32'd3);
      check_val("run1_valid", {31'd0, bus.oValid}, 32'd1);
      check_val("run1_time", {18'd0, bus.oTimeMs}, 32'd7);
      check_val("run1_best", {18'd0, bus.oBest}, 32'd7);
      check_val("run1_go", {31'd0, bus.oGo}, 32'd0);
      wait_cycles(1);
      check_val("run1_valid_pulse", {31'd0, bus.oValid}, 32'd0);
      check_val("run1_hold", {29'd0, bus.oState}, 32'd3);

      // Run 2: a slower 9 ms result keeps the best time at 7.
      press_key(lval);
      check_val("arm2_state", {29'd0, bus.oState}, 32'd1);
      wait_go("run2", lval);
      wait_cycles(36);
      press_key(lval);
      check_val("run2_time", {18'd0, bus.oTimeMs}, 32'd9);
      check_val("run2_valid", {31'd0, bus.oValid}, 32'd1);
      check_val("run2_best", {18'd0, bus.oBest}, 32'd7);

      // Early press during ARMED.
      press_key(lval);
      wait_cycles(5);
      check_val("early_armed_go", {31'd0, bus.oGo}, 32'd0);
      press_key(lval);
      check_val("early_state", {29'd0, bus.oState}, 32'd4);
      check_val("early_time", {18'd0, bus.oTimeMs}, 32'd9);
      check_val("early_best", {18'd0, bus.oBest}, 32'd7);
      check_val("early_valid", {31'd0, bus.oValid}, 32'd0);
      check_val("early_go", {31'd0, bus.oGo}, 32'd0);
      wait_cycles(3);
      check_val("early_hold", {29'd0, bus.oState}, 32'd4);

      // Re-arm from EARLY, then time out without a press.
      press_key(lval);
      check_val("rearm_state", {29'd0, bus.oState}, 32'd1);
      wait_go("tmo", lval);
      wait_cycles(79);
      check_val("tmo_still_go", {29'd0, bus.oState}, 32'd2);
      wait_cycles(1);
      check_val("tmo_state", {29'd0, bus.oState}, 32'd5);
      check_val("tmo_time", {18'd0, bus.oTimeMs}, 32'd20);
      check_val("tmo_valid", {31'd0, bus.oValid}, 32'd0);
      check_val("tmo_go", {31'd0, bus.oGo}, 32'd0);
      check_val("tmo_best", {18'd0, bus.oBest}, 32'd7);

      // Press on the same cycle as the 20th tick takes the RESULT path.
      press_key(lval);
      wait_go("max", lval);
      wait_cycles(79);
      press_key(lval);
      check_val("max_state", {29'd0, bus.oState}, 32'd3);
      check_val("max_time", {18'd0, bus.oTimeMs}, 32'd20);
      check_val("max_valid", {31'd0, bus.oValid}, 32'd1);
      check_val("max_best", {18'd0, bus.oBest}, 32'd7);

      // Drop iEnable in GO.
      press_key(lval);
      wait_go("en", lval);
      wait_cycles(10);
      bus.iEnable = 1'b0;
      wait_cycles(1);
      check_val("en_state", {29'd0, bus.oState}, 32'd0);
      check_val("en_go", {31'd0, bus.oGo}, 32'd0);
      check_val("en_time", {18'd0, bus.oTimeMs}, 32'd20);
      check_val("en_best", {18'd0, bus.oBest}, 32'd7);
      press_key(lval);
      check_val("en_press_ignored", {29'd0, bus.oState}, 32'd0);

      // Assert iReset asynchronously in the middle of GO.
      bus.iEnable = 1'b1;
      wait_cycles(1);
      press_key(lval);
      wait_go("rst", lval);
      wait_cycles(5);
      iReset = 1'b1;
      #1;
      check_val("arst_state", {29'd0, bus.oState}, 32'd0);
      check_val("arst_best", {18'd0, bus.oBest}, 32'h3FFF);
      check_val("arst_time", {18'd0, bus.oTimeMs}, 32'd0);
      check_val("arst_go", {31'd0, bus.oGo}, 32'd0);
      check_val("arst_valid", {31'd0, bus.oValid}, 32'd0);
      #2;
      iReset = 1'b0;
      wait_cycles(10);
      check_val("arst_idle_wait", {29'd0, bus.oState}, 32'd0);
      check_val("arst_idle_valid", {31'd0, bus.oValid}, 32'd0);
      press_key(lval);
      check_val("arst_rearm", {29'd0, bus.oState}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
